// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory fetch bus between the fetch unit and instruction memory.
//   imem_req    : fetch request, one cycle per fetch
//   imem_addr   : word-aligned fetch address
//   imem_rvalid : response valid
//   imem_rdata  : instruction word
// The fetch unit uses the master modport and the memory uses the slave modport.
interface instr_fetch_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_rvalid;
  logic [DATA_WIDTH-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_rvalid, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_rvalid, output imem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch unit with redirect and field decode.
//   i_clk, i_reset      : clock, asynchronous active-high reset
//   imem (master)       : request/response bus to instruction memory
//   o_instr_valid       : held instruction is presented to decode
//   i_decode_ready      : decode accepts the held instruction this cycle
//   o_op_code .. o_rs2  : bit-slice fields of the held word
//   o_instr, o_pc, o_pc_plus4 : held word, its address, and that address + 4
//   i_redirect, i_redirect_target : taken branch/jump and its target
//   o_misaligned_err    : sticky flag, set by any redirect target with bits[1:0] != 0
//   o_illegal_instr     : unknown opcode in VALID (only with FETCH_ILLEGAL_CHECK_EN)
// Optional feature macro: FETCH_ILLEGAL_CHECK_EN enables the opcode legality check.
// When the macro is not defined, o_illegal_instr is held at 0.
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    DATA_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR  = '0,
  parameter int                    OP_CODE_WIDTH = 7,
  parameter int                    FUNCT3_WIDTH  = 3,
  parameter int                    FUNCT7_WIDTH  = 7
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  instr_fetch_unit_if.master       imem,
  output logic                     o_instr_valid,
  input  logic                     i_decode_ready,
  output logic [OP_CODE_WIDTH-1:0] o_op_code,
  output logic [FUNCT3_WIDTH-1:0]  o_funct3,
  output logic [FUNCT7_WIDTH-1:0]  o_funct7,
  output logic [4:0]               o_rd,
  output logic [4:0]               o_rs1,
  output logic [4:0]               o_rs2,
  output logic [DATA_WIDTH-1:0]    o_instr,
  output logic [ADDR_WIDTH-1:0]    o_pc,
  output logic [ADDR_WIDTH-1:0]    o_pc_plus4,
  input  logic                     i_redirect,
  input  logic [ADDR_WIDTH-1:0]    i_redirect_target,
  output logic                     o_misaligned_err,
  output logic                     o_illegal_instr
);

  typedef enum logic [1:0] {ISSUE, WAIT, VALID, DISCARD} state_e;

  state_e                 state_q;
  logic [ADDR_WIDTH-1:0]  pc_q;      // next fetch address
  logic [ADDR_WIDTH-1:0]  ipc_q;     // address of the held instruction
  logic [DATA_WIDTH-1:0]  instr_q;
  logic                   misaligned_q;

  // Misaligned targets are forced to a word boundary and flagged.
  logic [ADDR_WIDTH-1:0]  tgt_aligned;
  assign tgt_aligned = {i_redirect_target[ADDR_WIDTH-1:2], 2'b00};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ISSUE;
      pc_q         <= RESET_VECTOR;
      ipc_q        <= '0;
      instr_q      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      if (i_redirect) begin
        pc_q <= tgt_aligned;
        if (i_redirect_target[1:0] != 2'b00) misaligned_q <= 1'b1;
      end
      unique case (state_q)
        // The request goes out this cycle. On a redirect, the request is reissued
        // at the new target. Any response to the abandoned request arrives in
        // ISSUE and is ignored there.
        ISSUE: state_q <= i_redirect ? ISSUE : WAIT;
        WAIT: begin
          if (i_redirect)
            state_q <= imem.imem_rvalid ? ISSUE : DISCARD;
          else if (imem.imem_rvalid) begin
            instr_q <= imem.imem_rdata;
            ipc_q   <= pc_q;
            pc_q    <= pc_q + ADDR_WIDTH'(4);   // wraps modulo 2^ADDR_WIDTH
            state_q <= VALID;
          end
        end
        VALID: if (i_redirect || i_decode_ready) state_q <= ISSUE;
        // Drop the response that is still in flight. A further redirect only
        // updates pc_q. If that redirect arrives together with the dropped
        // response, no request is outstanding, so the unit can issue again.
        DISCARD: if (imem.imem_rvalid) state_q <= ISSUE;
        default: state_q <= ISSUE;
      endcase
    end
  end

  assign imem.imem_req  = (state_q == ISSUE) && !i_reset;
  assign imem.imem_addr = pc_q;

  assign o_instr_valid    = (state_q == VALID);
  assign o_instr          = instr_q;
  assign o_op_code        = instr_q[6:0];
  assign o_rd             = instr_q[11:7];
  assign o_funct3         = instr_q[14:12];
  assign o_rs1            = instr_q[19:15];
  assign o_rs2            = instr_q[24:20];
  assign o_funct7         = instr_q[31:25];
  assign o_pc             = ipc_q;
  assign o_pc_plus4       = ipc_q + ADDR_WIDTH'(4);
  assign o_misaligned_err = misaligned_q;

`ifdef FETCH_ILLEGAL_CHECK_EN
  logic op_known;
  always_comb begin
    op_known = 1'b0;
    case (instr_q[6:0])
      7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
      7'b1100011, 7'b1101111, 7'b1100111: op_known = 1'b1;
      default: op_known = 1'b0;
    endcase
  end
  assign o_illegal_instr = (state_q == VALID) && !op_known;
`else
  assign o_illegal_instr = 1'b0;
`endif

endmodule
